// File: rtl/vec_word_packer.sv
// vec_word_packer
// Packs narrow words arriving on a val/rdy stream into one wide message,
// LSB-first. A message is released when NWORDS words have arrived, or
// earlier when a word carries recv_last. Unfilled slots read as zero.
// recv_rdy depends on send_rdy only in SEND. Because of that, a finished
// message can be drained in the same cycle the next message's first word
// is taken, so the stream keeps one word per cycle with no bubbles.

module vec_word_packer #(
    parameter  int WORD_W = 32,
    parameter  int NWORDS = 4,
    localparam int CNT_W  = $clog2(NWORDS) + 1
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic [WORD_W-1:0]        recv_msg,
    input  logic                     recv_last,
    input  logic                     recv_val,
    output logic                     recv_rdy,

    output logic [WORD_W*NWORDS-1:0] send_msg,
    output logic [CNT_W-1:0]         send_cnt,
    output logic                     send_val,
    input  logic                     send_rdy
);

    localparam int MSG_W = WORD_W * NWORDS;

    // FILL: collecting words. SEND: holding a complete message for downstream.
    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    // Index of the slot that completes a full message.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] idx_q,   idx_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [MSG_W-1:0] buf_q,   buf_d;

    logic recv_fire;
    logic send_fire;

    // A NWORDS==1 packer closes every message on its first word.
    logic single_slot;
    assign single_slot = (NWORDS == 1);

    // Handshake outputs depend only on state and on send_rdy.
    always_comb begin
        send_val = (state_q == SEND);
        recv_rdy = (state_q == FILL) ? 1'b1 : send_rdy;
    end

    assign recv_fire = recv_val && recv_rdy;
    assign send_fire = send_val && send_rdy;

    assign send_msg = buf_q;
    assign send_cnt = cnt_q;

    // Next-state logic for the state, fill index, word count and message buffer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;

        case (state_q)
            FILL: begin
                if (recv_fire) begin
                    // Drop the word into the slot selected by idx.
                    for (int i = 0; i < NWORDS; i++) begin
                        if (idx_q == CNT_W'(i)) begin
                            buf_d[i*WORD_W +: WORD_W] = recv_msg;
                        end
                    end

                    if ((idx_q == LAST_IDX) || recv_last) begin
                        state_d = SEND;
                        cnt_d   = idx_q + ONE;
                        idx_d   = '0;
                    end else begin
                        idx_d   = idx_q + ONE;
                    end
                end
            end

            SEND: begin
                if (send_fire) begin
                    // The message just left. Start the next one from a clean
                    // buffer so that short messages carry zero padding.
                    buf_d = '0;
                    idx_d = '0;

                    if (recv_fire) begin
                        // Back-to-back case: the first word of the next message
                        // arrives in the cycle the previous one is consumed.
                        buf_d[WORD_W-1:0] = recv_msg;

                        if (single_slot || recv_last) begin
                            state_d = SEND;
                            cnt_d   = ONE;
                        end else begin
                            state_d = FILL;
                            idx_d   = ONE;
                        end
                    end else begin
                        state_d = FILL;
                    end
                end
            end

            default: begin
                state_d = FILL;
                idx_d   = '0;
            end
        endcase
    end

    // State, index and count registers. An asynchronous reset drops any partial
    // or pending message.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Message buffer. Reset clears it, so no residue from a dropped message
    // can show up in a later one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

endmodule

// File: tb/tb_vec_word_packer.sv
// tb_vec_word_packer
// Directed bench for vec_word_packer with WORD_W=32 and NWORDS=4. Inputs change
// 1 ns after a rising edge. Outputs are sampled at least 1 ns after a rising
// edge and never on it.

module tb_vec_word_packer;

    localparam int WORD_W = 32;
    localparam int NWORDS = 4;
    localparam int CNT_W  = $clog2(NWORDS) + 1;
    localparam int MSG_W  = WORD_W * NWORDS;

    logic              clk;
    logic              reset;
    logic [WORD_W-1:0] recv_msg;
    logic              recv_last;
    logic              recv_val;
    logic              recv_rdy;
    logic [MSG_W-1:0]  send_msg;
    logic [CNT_W-1:0]  send_cnt;
    logic              send_val;
    logic              send_rdy;

    int errors;
    int checks;

    vec_word_packer #(
        .WORD_W (WORD_W),
        .NWORDS (NWORDS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .recv_msg  (recv_msg),
        .recv_last (recv_last),
        .recv_val  (recv_val),
        .recv_rdy  (recv_rdy),
        .send_msg  (send_msg),
        .send_cnt  (send_cnt),
        .send_val  (send_val),
        .send_rdy  (send_rdy)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it when it does not match.
    task automatic check(input string tag, input logic [MSG_W-1:0] got,
                         input logic [MSG_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [MSG_W-1:0] pack4(input logic [31:0] w0,
                                                 input logic [31:0] w1,
                                                 input logic [31:0] w2,
                                                 input logic [31:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    // Presents one word for a single cycle. Only used while the packer is in FILL.
    task automatic feed_word(input logic [31:0] w, input logic last);
        recv_val  = 1'b1;
        recv_msg  = w;
        recv_last = last;
        @(posedge clk);
        #1;
        recv_val  = 1'b0;
        recv_last = 1'b0;
        recv_msg  = '0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    logic [MSG_W-1:0] held_msg;
    logic [MSG_W-1:0] exp_msg;
    int               msgs_seen;
    int               stalls;

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        recv_val  = 1'b0;
        recv_last = 1'b0;
        recv_msg  = '0;
        send_rdy  = 1'b1;

        // Reset state
        #3;
        check("rst_send_val", MSG_W'(send_val), MSG_W'(0));
        check("rst_recv_rdy", MSG_W'(recv_rdy), MSG_W'(1));
        check("rst_send_cnt", MSG_W'(send_cnt), MSG_W'(0));
        check("rst_send_msg", send_msg, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();

        // Full pack of four words
        feed_word(32'h11, 1'b0);
        feed_word(32'h22, 1'b0);
        feed_word(32'h33, 1'b0);
        check("full_pre_val", MSG_W'(send_val), MSG_W'(0));
        feed_word(32'h44, 1'b0);
        check("full_val", MSG_W'(send_val), MSG_W'(1));
        check("full_msg", send_msg, pack4(32'h11, 32'h22, 32'h33, 32'h44));
        check("full_cnt", MSG_W'(send_cnt), MSG_W'(4));
        step();
        check("full_val_drop", MSG_W'(send_val), MSG_W'(0));
        check("full_rdy_back", MSG_W'(recv_rdy), MSG_W'(1));

        // Early last: two words, upper slots padded with zero
        feed_word(32'hAA, 1'b0);
        feed_word(32'hBB, 1'b1);
        check("early_val", MSG_W'(send_val), MSG_W'(1));
        check("early_msg", send_msg, pack4(32'hAA, 32'hBB, 32'h0, 32'h0));
        check("early_cnt", MSG_W'(send_cnt), MSG_W'(2));
        step();
        check("early_drain", MSG_W'(send_val), MSG_W'(0));

        // recv_last on the first word
        feed_word(32'hC0FFEE, 1'b1);
        check("first_last_msg", send_msg, pack4(32'hC0FFEE, 32'h0, 32'h0, 32'h0));
        check("first_last_cnt", MSG_W'(send_cnt), MSG_W'(1));
        step();

        // recv_val low: recv_msg and recv_last are ignored
        recv_msg  = 32'hBAD;
        recv_last = 1'b1;
        step();
        step();
        check("idle_no_val", MSG_W'(send_val), MSG_W'(0));
        recv_last = 1'b0;

        // Backpressure: send_rdy held low for 5 cycles
        send_rdy = 1'b0;
        feed_word(32'h1, 1'b0);
        feed_word(32'h2, 1'b0);
        feed_word(32'h3, 1'b0);
        feed_word(32'h4, 1'b1);
        held_msg = pack4(32'h1, 32'h2, 32'h3, 32'h4);
        recv_val = 1'b1;
        recv_msg = 32'h55;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_val", MSG_W'(send_val), MSG_W'(1));
            check("bp_rdy", MSG_W'(recv_rdy), MSG_W'(0));
            check("bp_msg", send_msg, held_msg);
            step();
        end
        check("bp_cnt", MSG_W'(send_cnt), MSG_W'(4));
        send_rdy = 1'b1;
        #1;
        check("bp_rdy_comb", MSG_W'(recv_rdy), MSG_W'(1));
        @(posedge clk);
        #1;
        recv_val = 1'b0;
        check("bp_released", MSG_W'(send_val), MSG_W'(0));
        feed_word(32'h66, 1'b0);
        feed_word(32'h77, 1'b0);
        feed_word(32'h88, 1'b0);
        check("bp_next_msg", send_msg, pack4(32'h55, 32'h66, 32'h77, 32'h88));
        check("bp_next_cnt", MSG_W'(send_cnt), MSG_W'(4));
        step();

        // Streaming: 12 words with send_rdy high throughout
        msgs_seen = 0;
        stalls    = 0;
        for (int k = 0; k < 13; k++) begin
            recv_val = (k < 12);
            recv_msg = 32'h100 + 32'(k);
            #1;
            if (k < 12 && recv_rdy !== 1'b1) stalls++;
            @(posedge clk);
            #1;
            if (send_val === 1'b1) begin
                exp_msg = pack4(32'h100 + 32'(4*msgs_seen),     32'h100 + 32'(4*msgs_seen + 1),
                                32'h100 + 32'(4*msgs_seen + 2), 32'h100 + 32'(4*msgs_seen + 3));
                check("stream_msg", send_msg, exp_msg);
                check("stream_cnt", MSG_W'(send_cnt), MSG_W'(4));
                msgs_seen++;
            end
        end
        recv_val = 1'b0;
        check("stream_count", MSG_W'(msgs_seen), MSG_W'(3));
        check("stream_stalls", MSG_W'(stalls), MSG_W'(0));
        step();

        // Single-word messages back to back
        recv_val  = 1'b1;
        recv_last = 1'b1;
        for (int k = 0; k < 5; k++) begin
            recv_msg = 32'hA000 + 32'(k);
            #1;
            check("single_rdy", MSG_W'(recv_rdy), MSG_W'(1));
            @(posedge clk);
            #1;
            check("single_val", MSG_W'(send_val), MSG_W'(1));
            check("single_msg", send_msg, pack4(32'hA000 + 32'(k), 32'h0, 32'h0, 32'h0));
            check("single_cnt", MSG_W'(send_cnt), MSG_W'(1));
        end
        recv_val  = 1'b0;
        recv_last = 1'b0;
        step();
        check("single_drain", MSG_W'(send_val), MSG_W'(0));

        // Reset after 2 of 4 words
        feed_word(32'hDEAD0001, 1'b0);
        feed_word(32'hDEAD0002, 1'b0);
        reset = 1'b1;
        #1;
        check("midrst_val", MSG_W'(send_val), MSG_W'(0));
        check("midrst_rdy", MSG_W'(recv_rdy), MSG_W'(1));
        check("midrst_msg", send_msg, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        feed_word(32'hA1, 1'b0);
        feed_word(32'hA2, 1'b0);
        feed_word(32'hA3, 1'b0);
        feed_word(32'hA4, 1'b0);
        check("midrst_next_msg", send_msg, pack4(32'hA1, 32'hA2, 32'hA3, 32'hA4));
        check("midrst_next_cnt", MSG_W'(send_cnt), MSG_W'(4));
        step();

        // Reset while a message waits for a stalled downstream
        send_rdy = 1'b0;
        feed_word(32'hE1, 1'b0);
        feed_word(32'hE2, 1'b1);
        check("pend_val", MSG_W'(send_val), MSG_W'(1));
        #2;
        reset = 1'b1;
        #1;
        check("pend_rst_val", MSG_W'(send_val), MSG_W'(0));
        check("pend_rst_cnt", MSG_W'(send_cnt), MSG_W'(0));
        @(posedge clk);
        #1;
        reset    = 1'b0;
        send_rdy = 1'b1;
        step();
        check("pend_after_val", MSG_W'(send_val), MSG_W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Upper bound on run time so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
